// File: rtl/fir_mac_if.sv
// fir_mac_if: loader-side handshake and data bus of the FIR MAC engine
interface fir_mac_if #(parameter int DATA_W = 16) ();
  logic              clear;
  logic              load_coeff;
  logic [1:0]        coefficient_num;
  logic [DATA_W-1:0] coeff_value;
  logic              data_ready;
  logic [DATA_W-1:0] sample_data;
  logic              modwait;
  logic [DATA_W-1:0] fir_out;
  logic              data_out_valid;
  logic              err;
  modport master (
    output clear, load_coeff, coefficient_num, coeff_value, data_ready, sample_data,
    input  modwait, fir_out, data_out_valid, err
  );
  modport slave (
    input  clear, load_coeff, coefficient_num, coeff_value, data_ready, sample_data,
    output modwait, fir_out, data_out_valid, err
  );
endinterface

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: 4-tap alternating-sign FIR with one shared multiply-accumulate
module fir_mac_engine #(
  parameter int DATA_W = 16
) (
  input logic      clk,
  input logic      n_reset,
  fir_mac_if.slave bus
);
  localparam int P = 2 * DATA_W;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t              state, state_n;
  logic [DATA_W-1:0]   coeff [4];
  logic [DATA_W-1:0]   s [4];
  logic signed [P+1:0] acc, acc_n, prod_x;
  logic [P-1:0]        prod;
  logic [1:0]          tap;
  logic                load_pending, accept, drop, neg, ovf;
  logic [DATA_W-1:0]   res;
  assign accept = state == IDLE && bus.data_ready && !bus.load_coeff && !load_pending && !bus.clear;
  assign drop   = bus.data_ready && !accept && !bus.clear;
  assign prod   = P'(s[tap]) * P'(coeff[tap]);
  assign prod_x = {2'b00, prod};
  assign acc_n  = tap[0] ? acc - prod_x : acc + prod_x;
  assign neg    = acc[P+1];
  assign ovf    = |acc[P+1:P-1];
  assign res    = neg ? '0 : ovf ? '1 : acc[P-2:DATA_W-1];
  // state register
  always_ff @(posedge clk)
    state <= n_reset ? IDLE : state_n;
  // next-state: clear aborts, MAC runs four taps, DONE lasts one cycle
  always_comb
    state_n = bus.clear ? IDLE :
              state == IDLE ? (accept ? MAC : IDLE) :
              state == MAC  ? (tap == 2'd3 ? DONE : MAC) : IDLE;
  // busy indication back to the loader, purely from registers
  always_comb
    bus.modwait = state != IDLE || load_pending;
  // coefficients, sample history, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (n_reset) begin
      coeff              <= '{default: '0};
      s                  <= '{default: '0};
      acc                <= '0;
      tap                <= '0;
      bus.fir_out        <= '0;
      bus.data_out_valid <= 1'b0;
      bus.err            <= 1'b0;
      load_pending       <= 1'b0;
    end else begin
      load_pending       <= bus.load_coeff;
      bus.data_out_valid <= !bus.clear && state == DONE;
      if (bus.load_coeff) coeff[bus.coefficient_num] <= bus.coeff_value;
      if (bus.clear) begin
        s           <= '{default: '0};
        acc         <= '0;
        bus.fir_out <= '0;
        bus.err     <= 1'b0;
      end else begin
        if (accept) begin
          s   <= '{bus.sample_data, s[0], s[1], s[2]};
          acc <= '0;
          tap <= '0;
        end
        if (state == MAC) begin
          acc <= acc_n;
          tap <= tap + 2'd1;
        end
        if (state == DONE) begin
          bus.fir_out <= res;
          bus.err     <= neg || ovf || drop;
        end else if (drop) bus.err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed vectors for the FIR MAC engine
module tb_fir_mac_engine;
  logic clk = 1'b0;
  logic n_reset = 1'b1;
  int total = 0;
  int bad = 0;
  fir_mac_if #(.DATA_W(16)) bus ();
  fir_mac_engine #(.DATA_W(16)) dut (.clk(clk), .n_reset(n_reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [1:0] idx, input logic [15:0] val);
    bus.coefficient_num = idx;
    bus.coeff_value = val;
    bus.load_coeff = 1'b1;
    @(negedge clk);
    bus.load_coeff = 1'b0;
  endtask
  task automatic send(input string tag, input logic [15:0] d, input logic [15:0] eo, input logic ee);
    int mw = 0;
    int nv = 0;
    logic [15:0] fo = 'x;
    logic fe = 1'bx;
    bus.sample_data = d;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mw += int'(bus.modwait);
      if (bus.data_out_valid) begin
        nv++;
        fo = bus.fir_out;
        fe = bus.err;
      end
      @(negedge clk);
    end
    check({tag, "_modwait_cycles"}, mw, 5);
    check({tag, "_valid_pulses"}, nv, 1);
    check({tag, "_fir_out"}, fo, eo);
    check({tag, "_err"}, fe, ee);
  endtask
  task automatic count_valid(input string tag, input int exp);
    int nv = 0;
    logic [15:0] fo = 'x;
    logic fe = 1'bx;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.data_out_valid) begin
        nv++;
        fo = bus.fir_out;
        fe = bus.err;
      end
    end
    check({tag, "_valid_pulses"}, nv, exp);
    if (exp == 1) begin
      check({tag, "_fir_out"}, fo, 16'd100);
      check({tag, "_err"}, fe, 0);
    end
  endtask
  initial begin
    bus.clear = 1'b0;
    bus.load_coeff = 1'b0;
    bus.coefficient_num = '0;
    bus.coeff_value = '0;
    bus.data_ready = 1'b0;
    bus.sample_data = '0;
    repeat (2) @(negedge clk);
    n_reset = 1'b0;
    check("rst_fir_out", bus.fir_out, 0);
    check("rst_valid", bus.data_out_valid, 0);
    check("rst_err", bus.err, 0);
    check("rst_modwait", bus.modwait, 0);
    load(2'd0, 16'h8000);
    @(negedge clk);
    bus.sample_data = 16'd5;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    n_reset = 1'b0;
    check("midrst_fir_out", bus.fir_out, 0);
    check("midrst_modwait", bus.modwait, 0);
    check("midrst_err", bus.err, 0);
    count_valid("midrst", 0);
    send("zero_coeff", 16'd7, 16'h0000, 1'b0);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    load(2'd0, 16'h8000);
    load(2'd1, 16'h4000);
    load(2'd2, 16'h2000);
    load(2'd3, 16'h0000);
    check("burst_modwait_hi", bus.modwait, 1);
    @(negedge clk);
    check("burst_modwait_lo", bus.modwait, 0);
    send("s100", 16'd100, 16'h0064, 1'b0);
    send("s40", 16'd40, 16'h0000, 1'b1);
    send("s300", 16'd300, 16'h0131, 1'b0);
    load(2'd1, 16'h0000);
    load(2'd2, 16'h8000);
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    send("ovf_a", 16'hFFFF, 16'hFFFF, 1'b0);
    send("ovf_b", 16'h0000, 16'h0000, 1'b0);
    send("ovf_c", 16'hFFFF, 16'hFFFF, 1'b1);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("clr_err", bus.err, 0);
    bus.sample_data = 16'd100;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    @(negedge clk);
    bus.sample_data = 16'd999;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    check("drop_err", bus.err, 1);
    count_valid("drop", 1);
    send("drop_hist", 16'd0, 16'h0000, 1'b0);
    send("hist2", 16'd100, 16'h00C8, 1'b0);
    bus.sample_data = 16'd50;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("clrmac_fir_out", bus.fir_out, 0);
    check("clrmac_modwait", bus.modwait, 0);
    count_valid("clrmac", 0);
    send("after_clr", 16'd100, 16'h0064, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
